// File: rtl/stopwatch_core_if.sv
// Handshake bundle between the stopwatch controller (master) and the
// stopwatch timebase (slave): single-cycle command strobes in, BCD count
// and status flags out.
interface stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      tick;
    logic                      start_stop;
    logic                      clear;
    logic                      lap;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic [4*NUM_DIGITS-1:0]   display_bcd;
    logic                      running;
    logic                      lap_active;
    logic                      overflow;

    modport master (
        output tick, start_stop, clear, lap,
        input  count_bcd, display_bcd, running, lap_active, overflow
    );

    modport slave (
        input  tick, start_stop, clear, lap,
        output count_bcd, display_bcd, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_core.sv
// Mixed-radix BCD stopwatch timebase: start/stop, clear, lap freeze and a
// wrap-or-saturate overflow policy, advanced by an external tick strobe.
module stopwatch_core #(
    parameter int          NUM_DIGITS  = 4,
    parameter logic [31:0] DIGIT_BASES = 32'h0000_6A6A,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_core_if.slave sw
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lap_q, lap_d;
    logic           lap_active_q, lap_active_d;
    logic           overflow_q, overflow_d;

    logic [W-1:0]          count_inc;
    logic [NUM_DIGITS:0]   lower_max;
    logic                  counted;
    logic                  all_max;
    logic                  sat_event;

    // Ripple carry: a digit advances only when every lower digit is at its
    // maximum; comparing with >= keeps an out-of-range digit from sticking.
    assign lower_max[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [3:0] BASE_M1 = DIGIT_BASES[4*gi +: 4] - 4'd1;
            logic [3:0] digit;
            logic       dig_max;
            assign digit   = count_q[4*gi +: 4];
            assign dig_max = (digit >= BASE_M1);
            assign lower_max[gi+1] = lower_max[gi] & dig_max;
            assign count_inc[4*gi +: 4] = lower_max[gi]
                                        ? (dig_max ? 4'd0 : digit + 4'd1)
                                        : digit;
        end
    endgenerate

    assign all_max = lower_max[NUM_DIGITS];
    assign counted = sw.tick && (state_q == RUN);

    // State register and all datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic, priority clear > tick > start_stop > lap.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        sat_event    = 1'b0;

        if (sw.clear) begin
            state_d      = IDLE;
            count_d      = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (counted) begin
                if (all_max) begin
                    overflow_d = 1'b1;
                    if (SATURATE) begin
                        sat_event = 1'b1;
                        state_d   = DONE;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_inc;
                end
            end

            // A saturating tick wins over a same-cycle start_stop.
            if (sw.start_stop && !sat_event) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = state_q;
                endcase
            end

            // Lap captures the pre-tick count; releasing is allowed outside RUN.
            if (sw.lap && (state_q != DONE) && !sat_event) begin
                if (lap_active_q) begin
                    lap_active_d = 1'b0;
                end else if (state_q == RUN) begin
                    lap_d        = count_q;
                    lap_active_d = 1'b1;
                end
            end
        end
    end

    // Outputs are registered values; display is a plain mux with no added latency.
    assign sw.count_bcd   = count_q;
    assign sw.display_bcd = lap_active_q ? lap_q : count_q;
    assign sw.running     = (state_q == RUN);
    assign sw.lap_active  = lap_active_q;
    assign sw.overflow    = overflow_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: three instances (default wrap, default saturate,
// two-digit 3x10) driven one at a time and compared against an integer model.
module tb_stopwatch_core;
    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
    always #5 clk = ~clk;

    stopwatch_core_if #(.NUM_DIGITS(4)) if_a ();
    stopwatch_core_if #(.NUM_DIGITS(4)) if_b ();
    stopwatch_core_if #(.NUM_DIGITS(2)) if_c ();

    stopwatch_core #(.NUM_DIGITS(4), .DIGIT_BASES(32'h0000_6A6A), .SATURATE(1'b0))
        dut_a (.clk(clk), .rst_n(rst_a), .sw(if_a.slave));
    stopwatch_core #(.NUM_DIGITS(4), .DIGIT_BASES(32'h0000_6A6A), .SATURATE(1'b1))
        dut_b (.clk(clk), .rst_n(rst_b), .sw(if_b.slave));
    stopwatch_core #(.NUM_DIGITS(2), .DIGIT_BASES(32'h0000_003A), .SATURATE(1'b0))
        dut_c (.clk(clk), .rst_n(rst_c), .sw(if_c.slave));

    int tests = 0;
    int fails = 0;

    // Reference model: count held as a plain integer number of ticks.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
    mst_t        m_st  [3];
    int          m_cnt [3];
    int          m_lap [3];
    bit          m_la  [3];
    bit          m_ov  [3];
    int          nd    [3] = '{4, 4, 2};
    logic [31:0] bases [3] = '{32'h6A6A, 32'h6A6A, 32'h003A};
    bit          sat   [3] = '{1'b0, 1'b1, 1'b0};

    function automatic int max_val(int w);
        int p = 1;
        for (int i = 0; i < nd[w]; i++) p = p * int'(bases[w][4*i +: 4]);
        return p - 1;
    endfunction

    function automatic logic [31:0] to_bcd(int w, int v);
        logic [31:0] r = '0;
        int          b;
        for (int i = 0; i < nd[w]; i++) begin
            b = int'(bases[w][4*i +: 4]);
            r[4*i +: 4] = 4'(v % b);
            v = v / b;
        end
        return r;
    endfunction

    task automatic model_reset(int w);
        m_st[w] = M_IDLE; m_cnt[w] = 0; m_lap[w] = 0; m_la[w] = 0; m_ov[w] = 0;
    endtask

    task automatic model_step(int w, bit c, bit t, bit s, bit l);
        mst_t old     = m_st[w];
        int   old_cnt = m_cnt[w];
        bit   sat_hit = 0;
        if (c) begin
            model_reset(w);
        end else begin
            if (t && old == M_RUN) begin
                if (m_cnt[w] == max_val(w)) begin
                    m_ov[w] = 1;
                    if (sat[w]) begin sat_hit = 1; m_st[w] = M_DONE; end
                    else m_cnt[w] = 0;
                end else begin
                    m_cnt[w] = m_cnt[w] + 1;
                end
            end
            if (s && !sat_hit) begin
                if (old == M_IDLE || old == M_PAUSE) m_st[w] = M_RUN;
                else if (old == M_RUN) m_st[w] = M_PAUSE;
            end
            if (l && old != M_DONE && !sat_hit) begin
                if (m_la[w]) m_la[w] = 0;
                else if (old == M_RUN) begin m_lap[w] = old_cnt; m_la[w] = 1; end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(int w, bit c, bit t, bit s, bit l);
        case (w)
            0: begin if_a.clear = c; if_a.tick = t; if_a.start_stop = s; if_a.lap = l; end
            1: begin if_b.clear = c; if_b.tick = t; if_b.start_stop = s; if_b.lap = l; end
            default: begin if_c.clear = c; if_c.tick = t; if_c.start_stop = s; if_c.lap = l; end
        endcase
    endtask

    task automatic sample(int w, output logic [31:0] cnt, output logic [31:0] disp,
                          output logic run, output logic la, output logic ov);
        case (w)
            0: begin cnt = 32'(if_a.count_bcd); disp = 32'(if_a.display_bcd);
                     run = if_a.running; la = if_a.lap_active; ov = if_a.overflow; end
            1: begin cnt = 32'(if_b.count_bcd); disp = 32'(if_b.display_bcd);
                     run = if_b.running; la = if_b.lap_active; ov = if_b.overflow; end
            default: begin cnt = 32'(if_c.count_bcd); disp = 32'(if_c.display_bcd);
                     run = if_c.running; la = if_c.lap_active; ov = if_c.overflow; end
        endcase
    endtask

    task automatic check_all(int w, string tag);
        logic [31:0] c, d;
        logic        r, la, ov;
        sample(w, c, d, r, la, ov);
        check({tag, ".count"},   c, to_bcd(w, m_cnt[w]));
        check({tag, ".display"}, d, to_bcd(w, m_la[w] ? m_lap[w] : m_cnt[w]));
        check({tag, ".running"}, 32'(r),  32'(m_st[w] == M_RUN));
        check({tag, ".lap_act"}, 32'(la), 32'(m_la[w]));
        check({tag, ".ovf"},     32'(ov), 32'(m_ov[w]));
    endtask

    // One clock: apply strobes, let the edge sample them, check 1 ns later.
    task automatic step(int w, bit c, bit t, bit s, bit l, string tag);
        drive(w, c, t, s, l);
        @(posedge clk);
        #1;
        model_step(w, c, t, s, l);
        drive(w, 0, 0, 0, 0);
        check_all(w, tag);
    endtask

    task automatic ticks(int w, int n, string tag);
        for (int i = 0; i < n; i++) step(w, 0, 1, 0, 0, tag);
    endtask

    task automatic random_run(int w, int n, string tag);
        bit c, t, s, l;
        for (int i = 0; i < n; i++) begin
            c = ($urandom_range(0, 59) == 0);
            t = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 7) == 0);
            step(w, c, t, s, l, tag);
        end
    endtask

    logic [31:0] oc, od;
    logic        orun, ola, oov;

    initial begin
        for (int w = 0; w < 3; w++) begin model_reset(w); drive(w, 0, 0, 0, 0); end
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) check_all(w, "reset");
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // 1: start, 75 ticks -> 0115
        step(0, 0, 0, 1, 0, "t1.start");
        ticks(0, 75, "t1.tick");
        sample(0, oc, od, orun, ola, oov);
        check("t1.const_count", oc, 32'h0115);
        check("t1.const_run", 32'(orun), 32'd1);

        // 2: wrap at 5959
        step(0, 1, 0, 0, 0, "t2.clear");
        step(0, 0, 0, 1, 0, "t2.start");
        ticks(0, 3599, "t2.fill");
        sample(0, oc, od, orun, ola, oov);
        check("t2.const_5959", oc, 32'h5959);
        step(0, 0, 1, 0, 0, "t2.wrap");
        sample(0, oc, od, orun, ola, oov);
        check("t2.const_wrap", oc, 32'h0000);
        check("t2.const_wrap_ovf", 32'(oov), 32'd1);

        // 2b: saturate at 5959
        step(1, 0, 0, 1, 0, "t2s.start");
        ticks(1, 3599, "t2s.fill");
        step(1, 0, 1, 0, 0, "t2s.sat");
        sample(1, oc, od, orun, ola, oov);
        check("t2s.const_hold", oc, 32'h5959);
        check("t2s.const_run", 32'(orun), 32'd0);
        step(1, 0, 0, 1, 0, "t2s.ss_ignored");
        step(1, 0, 1, 0, 1, "t2s.lap_ignored");
        step(1, 1, 0, 0, 0, "t2s.clear");

        // 3: lap freeze
        step(0, 1, 0, 0, 0, "t3.clear");
        step(0, 0, 0, 1, 0, "t3.start");
        ticks(0, 12, "t3.tick");
        step(0, 0, 0, 0, 1, "t3.lap");
        ticks(0, 5, "t3.frozen");
        sample(0, oc, od, orun, ola, oov);
        check("t3.const_disp", od, 32'h0012);
        check("t3.const_count", oc, 32'h0017);
        step(0, 0, 0, 0, 1, "t3.unlap");
        sample(0, oc, od, orun, ola, oov);
        check("t3.const_disp2", od, 32'h0017);

        // 4: tick with stopping start_stop is counted
        step(0, 1, 0, 0, 0, "t4.clear");
        step(0, 0, 1, 1, 0, "t4.start_tick");
        ticks(0, 9, "t4.tick");
        step(0, 0, 1, 1, 0, "t4.stop_tick");
        sample(0, oc, od, orun, ola, oov);
        check("t4.const_count", oc, 32'h0010);
        ticks(0, 3, "t4.paused");

        // 5: clear wins over everything
        step(0, 1, 0, 0, 0, "t5.clear");
        step(0, 0, 0, 1, 0, "t5.start");
        ticks(0, 33, "t5.tick");
        step(0, 0, 0, 0, 1, "t5.lap");
        step(0, 1, 1, 1, 0, "t5.clear_all");

        // 6: two-digit 3x10 instance, async reset mid-count
        step(2, 0, 0, 1, 0, "t6.start");
        ticks(2, 17, "t6.tick");
        #2;
        rst_c = 1'b0;
        #1;
        model_reset(2);
        check_all(2, "t6.async");
        @(posedge clk);
        #1;
        rst_c = 1'b1;
        step(2, 0, 0, 1, 0, "t6.restart");
        ticks(2, 30, "t6.wrap");
        sample(2, oc, od, orun, ola, oov);
        check("t6.const_count", oc, 32'h00);
        check("t6.const_ovf", 32'(oov), 32'd1);

        // Randomized traffic against the model
        random_run(0, 500, "rnd.a");
        random_run(1, 300, "rnd.b");
        random_run(2, 400, "rnd.c");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised stopwatch timebase that replaces the fixed three-counter cascade in the top level. It holds an N-digit mixed-radix BCD count, advanced by an external one-cycle tick strobe such as the output of the 1 s Clock divider. It adds start/stop, clear, lap-freeze and a selectable wrap/saturate overflow mode. Its display_bcd output feeds Display_Digits and the LED banks directly.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
DIGIT_BASES, 32'h0000_6A6A, packed 4 bits per digit, digit i at [4i+3:4i]; each base is 2..10; the default gives m10:m1:s10:s1 = 6,10,6,10.
SATURATE, 0, 0 = wrap to all-zero on overflow and keep running; 1 = hold at maximum and stop.

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
tick  in  1  count enable strobe, one clk cycle wide
start_stop  in  1  debounced single-cycle pulse; toggles run/pause
clear  in  1  single-cycle pulse; zeroes the count and all flags
lap  in  1  single-cycle pulse; toggles the lap freeze
count_bcd  out  4*NUM_DIGITS  live count, registered
display_bcd  out  4*NUM_DIGITS  lap-frozen value when lap_active, else count_bcd
running  out  1  high in RUN state
lap_active  out  1  display frozen
overflow  out  1  sticky; set when the count passes its maximum value

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count_bcd=0, lap register=0, lap_active=0, overflow=0, running=0. All flops release on the first clk edge after rst_n rises.
- States: IDLE (count zero, stopped), RUN, PAUSE, DONE (saturated, SATURATE=1 only).
- Transitions:
  - IDLE -start_stop-> RUN
  - RUN -start_stop-> PAUSE
  - PAUSE -start_stop-> RUN
  - RUN -saturating overflow-> DONE
  - any -clear-> IDLE
  - DONE ignores start_stop and lap.
- Priority in one cycle: clear > tick > start_stop > lap.
- A tick counts only if the registered state is RUN in that cycle. A tick arriving together with the start_stop that stops the watch is still counted. A tick arriving together with the start_stop that starts the watch is not counted.
- Count arithmetic, on a counted tick:
  - Digit 0 increments.
  - Digit i wraps to 0 when it equals base_i-1 and every lower digit is also at its maximum. Digit i+1 increments in the same edge (ripple carry evaluated combinationally, single-cycle update).
  - count_bcd changes on the clk edge that samples tick (latency 1).
- Overflow (all digits at maximum and a counted tick):
  - SATURATE=0: count becomes 0, overflow=1, state stays RUN.
  - SATURATE=1: count holds at maximum, overflow=1, state goes to DONE, running=0.
  - overflow is cleared only by clear or reset.
- Lap:
  - In RUN with lap_active=0: lap copies count_bcd into the lap register (the value before any same-cycle tick) and sets lap_active=1.
  - lap with lap_active=1 (any state except DONE): sets lap_active=0.
  - lap in IDLE/PAUSE with lap_active=0: ignored.
  - The count keeps advancing while frozen.
- display_bcd is a combinational mux of registered values, so there is no extra latency.
- clear during RUN with lap_active=1: everything returns to reset values on the next edge.
- Digit values must never exceed base-1. Unused bits of DIGIT_BASES above 4*NUM_DIGITS are ignored.

Test Plan:
1. Reset, start_stop, 75 ticks (defaults) -> count_bcd=16'h0115, running=1, overflow=0; each tick updates the count 1 cycle later.
2. Count at 16'h5959, SATURATE=0, one tick -> count_bcd=16'h0000, overflow=1, running=1. Repeat with SATURATE=1 -> count stays 16'h5959, overflow=1, running=0; subsequent start_stop has no effect until clear.
3. Run to 16'h0012, pulse lap, apply 5 more ticks -> display_bcd=16'h0012, count_bcd=16'h0017. Second lap -> display_bcd=16'h0017.
4. Assert tick and start_stop together while RUN at 16'h0009 -> count=16'h0010, state PAUSE. Then 3 ticks -> count unchanged.
5. clear, start_stop and tick in the same cycle at 16'h0033 with lap_active=1 -> count=0, state IDLE, lap_active=0, overflow=0.
6. NUM_DIGITS=2, DIGIT_BASES=8'h3A, rst_n pulled low asynchronously mid-count -> outputs zero immediately, without a clk edge. After release, 30 ticks -> count_bcd=8'h00 with overflow=1.
